uart_tx_arbiter: RTL

Round-robin scheduler that shares the single UART transmitter (TxDataLoad/TxDataIn/TxDone interface of the UART top) between NUM_REQ byte producers. It accepts one byte per grant and pulses TxDataLoad. It then waits for frame completion (TxDone rising edge) or a watchdog timeout, enforces an inter-frame gap, and re-arbitrates. It sits between on-chip clients and the UART top, in the same Clock domain.

---
 rtl/uart_pkg.sv | 19 +
 rtl/rr_pick.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART-side types and defaults: transmit-arbiter FSM states and timing constants
// for a 10 MHz system clock driving a 9600-baud UART.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } state_e;

  localparam int DATA_W_DEF      = 8;
  localparam int CLK_PERIOD_NS   = 100;
  localparam int BIT_CYCLES_9600 = 1042;
  // One 10-bit frame is ~10417 cycles; leave more than 2x margin before aborting.
  localparam int TIMEOUT_DEF     = 24000;
  localparam int GAP_DEF         = 2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request strictly after rr_ptr_i,
// wrapping modulo NUM_REQ, so the last winner gets the lowest priority.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [IW-1:0]      rr_ptr_i,
  output logic [IW-1:0]      winner_o,
  output logic               any_valid_o
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  // Scan from the farthest offset down so the nearest hit is assigned last and wins.
  always_comb begin
    winner_o    = '0;
    any_valid_o = 1'b0;
    sum         = '0;
    idx         = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      sum = {1'b0, rr_ptr_i} + (IW+1)'(off);
      if (sum >= (IW+1)'(NUM_REQ)) begin
        sum = sum - (IW+1)'(NUM_REQ);
      end
      idx = sum[IW-1:0];
      if (req_valid_i[idx]) begin
        winner_o    = idx;
        any_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between NUM_REQ byte producers:
// grant, load strobe, wait for TxDone rising edge or watchdog, inter-frame gap.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int GAP_CYCLES     = GAP_DEF,
  parameter int IW             = $clog2(NUM_REQ)
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic [NUM_REQ-1:0]          ReqValid,
  input  logic [NUM_REQ*DATA_W-1:0]   ReqData,
  output logic [NUM_REQ-1:0]          ReqReady,
  output logic                        TxDataLoad,
  output logic [DATA_W-1:0]           TxDataIn,
  input  logic                        TxDone,
  output logic                        Busy,
  output logic [IW-1:0]               GrantId,
  output logic                        TimeoutErr,
  output logic [15:0]                 FrameCount,
  output state_e                      DbgState
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  // Handshake: a requester holds ReqValid until its one-cycle ReqReady pulse; its byte is
  // sampled only on the grant edge, and ReqValid is ignored outside IDLE.
  state_e                state_q, state_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [IW-1:0]         grant_q, grant_d;
  logic [NUM_REQ-1:0]    ready_q, ready_d;
  logic                  load_q, load_d;
  logic                  tmo_q, tmo_d;
  logic [15:0]           frames_q, frames_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  done_q, done_d;

  logic [DATA_W-1:0]     req_bytes [NUM_REQ];
  logic [IW-1:0]         winner;
  logic                  any_valid;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
    assign req_bytes[i] = ReqData[i*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_pick (
    .req_valid_i (ReqValid),
    .rr_ptr_i    (rr_ptr_q),
    .winner_o    (winner),
    .any_valid_o (any_valid)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    grant_d  = grant_q;
    ready_d  = '0;
    load_d   = 1'b0;
    tmo_d    = 1'b0;
    frames_d = frames_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    done_d   = done_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          data_d   = req_bytes[winner];
          grant_d  = winner;
          rr_ptr_d = winner;
          ready_d  = NUM_REQ'(1) << winner;
          load_d   = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        // Capture TxDone here so a level already high is not mistaken for completion.
        cnt_d   = '0;
        done_d  = TxDone;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d  = cnt_q + CW'(1);
        done_d = TxDone;
        if (TxDone && !done_q) begin
          frames_d = frames_q + 16'd1;
          gap_d    = '0;
          state_d  = GAP;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          tmo_d   = 1'b1;
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= IW'(NUM_REQ - 1);
      data_q   <= '0;
      grant_q  <= '0;
      ready_q  <= '0;
      load_q   <= 1'b0;
      tmo_q    <= 1'b0;
      frames_q <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      grant_q  <= grant_d;
      ready_q  <= ready_d;
      load_q   <= load_d;
      tmo_q    <= tmo_d;
      frames_q <= frames_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      done_q   <= done_d;
    end
  end

  assign ReqReady   = ready_q;
  assign TxDataLoad = load_q;
  assign TxDataIn   = data_q;
  assign Busy       = (state_q != IDLE);
  assign GrantId    = grant_q;
  assign TimeoutErr = tmo_q;
  assign FrameCount = frames_q;
  assign DbgState   = state_q;

endmodule
